// File: rtl/frame_capture_writer.sv
// Frame capture writer: arms on request, aligns to the next frame start, packs RGB332 pixels
// into sequential buffer writes with saturation and overflow flagging. Optional checksum: FRAME_CAPTURE_WRITER_CHECKSUM_EN.
module frame_capture_writer #(
   parameter int MAX_PIXELS    = 40000,
   parameter int ADDRESS_WIDTH = 16
) (
   input  logic                     clock_pixel_in,
   input  logic                     reset_pixel_in,
   input  logic                     capture_request_in,
   input  logic [9:0]               pixel_red_data_in,
   input  logic [9:0]               pixel_green_data_in,
   input  logic [9:0]               pixel_blue_data_in,
   input  logic                     line_valid_in,
   input  logic                     frame_valid_in,
   output logic [ADDRESS_WIDTH-1:0] write_address_out,
   output logic [7:0]               write_data_out,
   output logic                     write_enable_out,
   output logic                     capture_busy_out,
   output logic                     capture_done_out,
   output logic [ADDRESS_WIDTH-1:0] pixel_count_out,
   output logic                     overflow_out,
   output logic [15:0]              checksum_out
);
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURING} state_t;

   localparam logic [ADDRESS_WIDTH-1:0] MAX_C = ADDRESS_WIDTH'(MAX_PIXELS);

   state_t                   state_q, state_d;
   logic                     fv_q;
   logic [ADDRESS_WIDTH-1:0] count_q, count_d, addr_q, addr_d;
   logic [7:0]               data_q, data_d;
   logic                     we_q, we_d, busy_q, done_q, done_d, ovf_q, ovf_d;
   logic                     take;

   logic pixel, fv_rise, fv_fall;
   logic [7:0] packed_px;
   logic unused_bits;
   assign pixel     = frame_valid_in && line_valid_in;
   assign fv_rise   = frame_valid_in && !fv_q;
   assign fv_fall   = !frame_valid_in && fv_q;
   assign packed_px = {pixel_red_data_in[9:7], pixel_green_data_in[9:7], pixel_blue_data_in[9:8]};
   assign unused_bits = ^{pixel_red_data_in[6:0], pixel_green_data_in[6:0], pixel_blue_data_in[7:0]};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      take    = 1'b0;
      case (state_q)
         IDLE: if (capture_request_in) begin
            state_d = ARMED;
            count_d = '0;
            ovf_d   = 1'b0;
         end
         // The edge cycle is the first cycle of the frame, so it may already carry a pixel.
         ARMED: if (fv_rise) begin
            state_d = CAPTURING;
            take    = pixel;
         end
         CAPTURING: begin
            if (fv_fall) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               take = pixel;
            end
         end
         default: state_d = IDLE;
      endcase
      if (take) begin
         if (count_q < MAX_C) begin
            we_d    = 1'b1;
            addr_d  = count_q;
            data_d  = packed_px;
            count_d = count_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_pixel_in or posedge reset_pixel_in) begin
      if (reset_pixel_in) begin
         state_q <= IDLE;
         fv_q    <= 1'b0;
         count_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fv_q    <= frame_valid_in;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef FRAME_CAPTURE_WRITER_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;
   always_comb begin
      sum_d = sum_q;
      if (state_q == IDLE && capture_request_in) sum_d = '0;
      else if (we_d)                             sum_d = sum_q + {8'h00, data_d};
   end
   always_ff @(posedge clock_pixel_in or posedge reset_pixel_in) begin
      if (reset_pixel_in) sum_q <= '0;
      else                sum_q <= sum_d;
   end
   assign checksum_out = sum_q;
`else
   assign checksum_out = '0;
`endif

   assign write_address_out = addr_q;
   assign write_data_out    = data_q;
   assign write_enable_out  = we_q;
   assign capture_busy_out  = busy_q;
   assign capture_done_out  = done_q;
   assign pixel_count_out   = count_q;
   assign overflow_out      = ovf_q;
endmodule

// File: tb/tb_frame_capture_writer.sv
// Randomized frame-level bench for frame_capture_writer against a per-frame reference model.
module tb_frame_capture_writer;
   localparam int MAXP = 24;
   localparam int AW   = 16;

   logic          clk = 1'b0, rst = 1'b1, req = 1'b0, lv = 1'b0, fv = 1'b0;
   logic [9:0]    r = '0, g = '0, b = '0;
   logic [AW-1:0] addr, cnt;
   logic [7:0]    data;
   logic          we, busy, done, ovf;
   logic [15:0]   csum;

   frame_capture_writer #(.MAX_PIXELS(MAXP), .ADDRESS_WIDTH(AW)) dut (
      .clock_pixel_in(clk), .reset_pixel_in(rst), .capture_request_in(req),
      .pixel_red_data_in(r), .pixel_green_data_in(g), .pixel_blue_data_in(b),
      .line_valid_in(lv), .frame_valid_in(fv),
      .write_address_out(addr), .write_data_out(data), .write_enable_out(we),
      .capture_busy_out(busy), .capture_done_out(done), .pixel_count_out(cnt),
      .overflow_out(ovf), .checksum_out(csum)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // observed writes and done pulses
   logic [AW+7:0] act_q[$];
   int            done_cnt = 0;
   always @(negedge clk) begin
      if (we) act_q.push_back({addr, data});
      if (done) begin
         done_cnt++;
         chk("busy_at_done", 32'(busy), 32'd0);
      end
   end

   // reference model state, kept at frame granularity
   logic [AW+7:0] exp_q[$];
   bit            m_armed = 0;
   int            m_cnt = 0, m_sum = 0, exp_done = 0;
   bit            m_ovf = 0;

   function automatic logic [7:0] pack(input logic [9:0] rr, input logic [9:0] gg, input logic [9:0] bb);
      return {rr[9:7], gg[9:7], bb[9:8]};
   endfunction

   function automatic logic [15:0] exp_csum();
`ifdef FRAME_CAPTURE_WRITER_CHECKSUM_EN
      return 16'(m_sum);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_request(input bit capturing);
      if (!m_armed && !capturing) begin
         m_armed = 1;
         m_cnt = 0; m_ovf = 0; m_sum = 0;
      end
   endtask

   task automatic request();
      req = 1'b1;
      cyc();
      req = 1'b0;
      model_request(0);
      chk("req_busy", 32'(busy), 32'(m_armed));
      chk("req_count", 32'(cnt), 32'(m_cnt));
      chk("req_ovf", 32'(ovf), 32'(m_ovf));
      chk("req_csum", 32'(csum), 32'(exp_csum()));
   endtask

   // mode 0: random pixels, 1: r/b full g zero, 2: all full
   task automatic frame(input int nl, input int np, input bit req_in, input int mode);
      bit cap;
      int k;
      logic [7:0] byt;
      cap = m_armed;
      m_armed = 0;
      k = int'($urandom_range(0, 1));
      fv = 1'b1; lv = 1'b0;
      for (int c = 0; c < 2; c++) begin
         req = (req_in && c == k);
         cyc();
         if (req_in && c == k) model_request(cap);
      end
      req = 1'b0;
      for (int l = 0; l < nl; l++) begin
         for (int p = 0; p < np; p++) begin
            case (mode)
               1:       begin r = 10'h3FF; g = 10'h000; b = 10'h3FF; end
               2:       begin r = 10'h3FF; g = 10'h3FF; b = 10'h3FF; end
               default: begin r = 10'($urandom); g = 10'($urandom); b = 10'($urandom); end
            endcase
            lv = 1'b1;
            cyc();
            if (cap) begin
               byt = pack(r, g, b);
               if (m_cnt < MAXP) begin
                  exp_q.push_back({AW'(m_cnt), byt});
                  m_cnt++;
                  m_sum = (m_sum + byt) & 16'hFFFF;
               end else m_ovf = 1;
            end
         end
         lv = 1'b0;
         cyc(); cyc();
      end
      fv = 1'b0;
      if (cap) exp_done++;
      cyc(); cyc();
      // line valid outside a frame must be ignored
      lv = 1'b1; r = 10'($urandom); g = 10'($urandom); b = 10'($urandom);
      cyc(); cyc();
      lv = 1'b0;
      cyc(); cyc();
      chk("n_writes", 32'(act_q.size()), 32'(exp_q.size()));
      while (act_q.size() > 0 && exp_q.size() > 0)
         chk("addr_data", 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
      act_q.delete(); exp_q.delete();
      chk("done_pulses", 32'(done_cnt), 32'(exp_done));
      chk("pixel_count", 32'(cnt), 32'(m_cnt));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("checksum", 32'(csum), 32'(exp_csum()));
      chk("busy_after", 32'(busy), 32'(m_armed));
   endtask

   initial begin
      // reset held while frame_valid toggles
      for (int i = 0; i < 8; i++) begin
         fv = i[1]; lv = i[0];
         cyc();
         chk("rst_outputs", 32'({addr, data, we, busy, done, cnt, ovf, csum} != '0), 32'd0);
      end
      fv = 1'b0; lv = 1'b0;
      cyc();
      rst = 1'b0;
      cyc(); cyc();
      chk("rst_no_writes", 32'(act_q.size()), 32'd0);
      chk("rst_no_done", 32'(done_cnt), 32'd0);

      request(); frame(2, 3, 0, 1);          // six writes of 0xE3
      frame(1, 4, 0, 0);                     // no request: not captured
      frame(2, 3, 1, 0); frame(2, 4, 0, 0);  // mid-frame request: next frame captured
      request(); frame(6, 5, 0, 0);          // 30 pixels into 24-pixel buffer
      request(); frame(2, 3, 1, 0);          // request while capturing ignored
      frame(1, 3, 0, 0);
      request(); frame(1, 3, 0, 2);          // 3 x 0xFF
      for (int it = 0; it < 20; it++) begin
         if ($urandom_range(0, 1) == 1) request();
         frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 8)), $urandom_range(0, 3) == 0, 0);
      end

      // reset in the middle of a capture
      request();
      fv = 1'b1; cyc(); cyc();
      lv = 1'b1;
      for (int p = 0; p < 3; p++) begin r = 10'($urandom); g = 10'($urandom); b = 10'($urandom); cyc(); end
      rst = 1'b1;
      #1;
      chk("midrst_outputs", 32'({addr, data, we, busy, done, cnt, ovf, csum} != '0), 32'd0);
      cyc(); cyc();
      lv = 1'b0; fv = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      m_armed = 0; m_cnt = 0; m_ovf = 0; m_sum = 0;
      act_q.delete();
      cyc(); cyc();
      chk("midrst_no_done", 32'(done_cnt), 32'(exp_done));
      frame(2, 3, 0, 0);                     // not captured after reset

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
